// File: rtl/flash_rd_adapter_pkg.sv
// rtl/flash_rd_adapter_pkg.sv - shared TL-UL and flash geometry constants and types
//
// Purpose: widths of the TL-UL bus and of the flash macro read port, the
// A/D channel opcode encodings and the command-queue entry layout used by
// flash_rd_adapter.
// Ports: none (package).

package flash_rd_adapter_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_SZW = 2;

  // Flash word index is {bank, page, word}, bank in the MSBs.
  localparam int FLASH_BKW = 1;
  localparam int FLASH_PGW = 3;
  localparam int FLASH_WDW = 8;
  localparam int FLASH_AW  = FLASH_BKW + FLASH_PGW + FLASH_WDW;
  localparam int FLASH_DW  = 32;

  typedef enum logic [2:0] {
    TlPutFullData    = 3'd0,
    TlPutPartialData = 3'd1,
    TlGet            = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TlAccessAck     = 3'd0,
    TlAccessAckData = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    logic              is_get;
    logic              err;
  } cmd_entry_t;

endpackage

// File: rtl/flash_rd_fifo.sv
// rtl/flash_rd_fifo.sv - small synchronous FIFO with registered full/empty
//
// Purpose: first-word-fall-through FIFO; rdata_o shows the head entry
// whenever empty_o is low. Push while full and pop while empty are dropped.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, wdata_i   write strobe and data
//   pop_i             remove head entry
//   rdata_o           head entry
//   full_o, empty_o   occupancy flags, derived from the registered count

module flash_rd_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/flash_rd_adapter.sv
// rtl/flash_rd_adapter.sv - TL-UL Get to flash word-read adapter
//
// Purpose: accepts TL-UL requests for the flash window, issues word reads
// on the flash read port and returns in-order D responses. Illegal requests
// (non-Get, outside the window, size > 2, misaligned) are answered locally
// with an error and never reach flash.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   tl_a_*                             TL-UL A channel (request)
//   tl_d_*                             TL-UL D channel (response)
//   flash_req_o/addr_o/ack_i           flash read request handshake
//   flash_rvalid_i/rdata_i/rerr_i      flash read data return

module flash_rd_adapter
  import flash_rd_adapter_pkg::*;
#(
  parameter int              NumOutstanding = 2,
  parameter logic [TL_AW-1:0] BaseAddr      = 32'h2000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tl_a_valid_i,
  output logic              tl_a_ready_o,
  input  logic [2:0]        tl_a_opcode_i,
  input  logic [TL_AW-1:0]  tl_a_address_i,
  input  logic [TL_SZW-1:0] tl_a_size_i,
  input  logic [TL_AIW-1:0] tl_a_source_i,
  output logic              tl_d_valid_o,
  input  logic              tl_d_ready_i,
  output logic [2:0]        tl_d_opcode_o,
  output logic [TL_SZW-1:0] tl_d_size_o,
  output logic [TL_AIW-1:0] tl_d_source_o,
  output logic [TL_DW-1:0]  tl_d_data_o,
  output logic              tl_d_error_o,
  output logic              flash_req_o,
  output logic [FLASH_AW-1:0] flash_addr_o,
  input  logic              flash_ack_i,
  input  logic              flash_rvalid_i,
  input  logic [FLASH_DW-1:0] flash_rdata_i,
  input  logic              flash_rerr_i
);

  localparam int CmdW  = $bits(cmd_entry_t);
  localparam int DataW = FLASH_DW + 1;
  localparam int PendW = $clog2(NumOutstanding + 1);

  typedef enum logic {
    StIdle = 1'b0,
    StReq  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [FLASH_AW-1:0] addr_q;
  logic [PendW-1:0]  pend_q;

  logic addr_hit, size_ok, aligned, is_get, legal;
  logic a_fire, legal_fire, issue, rd_take;

  cmd_entry_t        cmd_in, cmd_head;
  logic [CmdW-1:0]   cmd_rdata;
  logic              cmd_full, cmd_empty, cmd_pop;
  logic [DataW-1:0]  data_rdata;
  logic              data_full, data_empty, data_pop;
  logic [FLASH_DW-1:0] head_rdata;
  logic              head_rerr;

  // Request legality
  assign addr_hit = (tl_a_address_i[TL_AW-1:FLASH_AW+2] == BaseAddr[TL_AW-1:FLASH_AW+2]);
  assign size_ok  = (tl_a_size_i <= TL_SZW'(2));
  always_comb begin
    aligned = 1'b0;
    case (tl_a_size_i)
      TL_SZW'(0): aligned = 1'b1;
      TL_SZW'(1): aligned = (tl_a_address_i[0] == 1'b0);
      TL_SZW'(2): aligned = (tl_a_address_i[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end
  assign is_get = (tl_a_opcode_i == TlGet);
  assign legal  = is_get && addr_hit && size_ok && aligned;

  assign tl_a_ready_o = (state_q == StIdle) && !cmd_full;
  assign a_fire       = tl_a_valid_i && tl_a_ready_o;
  assign legal_fire   = a_fire && legal;

  // Request FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (legal_fire) addr_q <= tl_a_address_i[FLASH_AW+1:2];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (legal_fire)  state_d = StReq;
      StReq:   if (flash_ack_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign flash_req_o  = (state_q == StReq);
  assign flash_addr_o = addr_q;

  // Reads issued to flash whose data has not yet returned. Read data is
  // only captured while this is non-zero, so stray rvalid pulses (including
  // ones for reads flushed by reset) never reach the data queue.
  assign issue   = flash_req_o && flash_ack_i;
  assign rd_take = flash_rvalid_i && (pend_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      case ({issue, rd_take})
        2'b10:   pend_q <= pend_q + PendW'(1);
        2'b01:   pend_q <= pend_q - PendW'(1);
        default: pend_q <= pend_q;
      endcase
    end
  end

  // Command and data queues
  assign cmd_in.source = tl_a_source_i;
  assign cmd_in.size   = tl_a_size_i;
  assign cmd_in.is_get = is_get;
  assign cmd_in.err    = !legal;

  flash_rd_fifo #(.Width(CmdW), .Depth(NumOutstanding)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (a_fire),
    .wdata_i (cmd_in),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_rdata),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  flash_rd_fifo #(.Width(DataW), .Depth(NumOutstanding)) u_data_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rd_take),
    .wdata_i ({flash_rdata_i, flash_rerr_i}),
    .pop_i   (data_pop),
    .rdata_o (data_rdata),
    .full_o  (data_full),
    .empty_o (data_empty)
  );

  assign cmd_head   = cmd_entry_t'(cmd_rdata);
  assign head_rdata = data_rdata[DataW-1:1];
  assign head_rerr  = data_rdata[0];

  // D channel: error heads answer without data; legal heads wait for data.
  assign tl_d_valid_o = !cmd_empty && (cmd_head.err || !data_empty);
  assign cmd_pop      = tl_d_valid_o && tl_d_ready_i;
  assign data_pop     = cmd_pop && !cmd_head.err;

  always_comb begin
    tl_d_opcode_o = 3'(TlAccessAck);
    tl_d_size_o   = '0;
    tl_d_source_o = '0;
    tl_d_data_o   = '0;
    tl_d_error_o  = 1'b0;
    if (tl_d_valid_o) begin
      tl_d_size_o   = cmd_head.size;
      tl_d_source_o = cmd_head.source;
      if (cmd_head.err) begin
        tl_d_opcode_o = cmd_head.is_get ? 3'(TlAccessAckData) : 3'(TlAccessAck);
        tl_d_error_o  = 1'b1;
      end else begin
        tl_d_opcode_o = 3'(TlAccessAckData);
        tl_d_data_o   = TL_DW'(head_rdata);
        tl_d_error_o  = head_rerr;
      end
    end
  end

endmodule

// File: tb/tb_flash_rd_adapter.sv
// tb/tb_flash_rd_adapter.sv - directed self-checking bench for flash_rd_adapter

module tb_flash_rd_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        tl_a_valid_i;
  logic        tl_a_ready_o;
  logic [2:0]  tl_a_opcode_i;
  logic [31:0] tl_a_address_i;
  logic [1:0]  tl_a_size_i;
  logic [7:0]  tl_a_source_i;
  logic        tl_d_valid_o;
  logic        tl_d_ready_i;
  logic [2:0]  tl_d_opcode_o;
  logic [1:0]  tl_d_size_o;
  logic [7:0]  tl_d_source_o;
  logic [31:0] tl_d_data_o;
  logic        tl_d_error_o;
  logic        flash_req_o;
  logic [11:0] flash_addr_o;
  logic        flash_ack_i;
  logic        flash_rvalid_i;
  logic [31:0] flash_rdata_i;
  logic        flash_rerr_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flash_rd_adapter #(.NumOutstanding(2), .BaseAddr(32'h2000_0000)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tl_a_valid_i   (tl_a_valid_i),
    .tl_a_ready_o   (tl_a_ready_o),
    .tl_a_opcode_i  (tl_a_opcode_i),
    .tl_a_address_i (tl_a_address_i),
    .tl_a_size_i    (tl_a_size_i),
    .tl_a_source_i  (tl_a_source_i),
    .tl_d_valid_o   (tl_d_valid_o),
    .tl_d_ready_i   (tl_d_ready_i),
    .tl_d_opcode_o  (tl_d_opcode_o),
    .tl_d_size_o    (tl_d_size_o),
    .tl_d_source_o  (tl_d_source_o),
    .tl_d_data_o    (tl_d_data_o),
    .tl_d_error_o   (tl_d_error_o),
    .flash_req_o    (flash_req_o),
    .flash_addr_o   (flash_addr_o),
    .flash_ack_i    (flash_ack_i),
    .flash_rvalid_i (flash_rvalid_i),
    .flash_rdata_i  (flash_rdata_i),
    .flash_rerr_i   (flash_rerr_i)
  );

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] size, input logic [7:0] src);
    tl_a_valid_i   = 1'b1;
    tl_a_opcode_i  = op;
    tl_a_address_i = addr;
    tl_a_size_i    = size;
    tl_a_source_i  = src;
  endtask

  task automatic idle_a();
    tl_a_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (tl_a_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_a_ready got %b want 1", tl_a_ready_o); end
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_d_valid got %b want 0", tl_d_valid_o); end
    n_cmp++; if (flash_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", flash_req_o); end
    n_cmp++; if (flash_addr_o !== 12'h000) begin n_bad++; $display("FAIL rst_addr got %h want 000", flash_addr_o); end
    n_cmp++; if (tl_d_opcode_o !== 3'd0) begin n_bad++; $display("FAIL rst_d_opcode got %0d want 0", tl_d_opcode_o); end
    n_cmp++; if (tl_d_size_o !== 2'd0) begin n_bad++; $display("FAIL rst_d_size got %0d want 0", tl_d_size_o); end
    n_cmp++; if (tl_d_source_o !== 8'h00) begin n_bad++; $display("FAIL rst_d_source got %h want 00", tl_d_source_o); end
    n_cmp++; if (tl_d_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_d_data got %h want 0", tl_d_data_o); end
    n_cmp++; if (tl_d_error_o !== 1'b0) begin n_bad++; $display("FAIL rst_d_error got %b want 0", tl_d_error_o); end
    rst = 1'b0;
  endtask

  task automatic test_get_legal();
    drive_a(3'd4, 32'h2000_0004, 2'd2, 8'h12);
    n_cmp++; if (tl_a_ready_o !== 1'b1) begin n_bad++; $display("FAIL get_a_ready got %b want 1", tl_a_ready_o); end
    @(negedge clk); idle_a();
    n_cmp++; if (flash_req_o !== 1'b1) begin n_bad++; $display("FAIL get_req got %b want 1", flash_req_o); end
    n_cmp++; if (flash_addr_o !== 12'h001) begin n_bad++; $display("FAIL get_addr got %h want 001", flash_addr_o); end
    n_cmp++; if (tl_a_ready_o !== 1'b0) begin n_bad++; $display("FAIL get_a_ready_busy got %b want 0", tl_a_ready_o); end
    flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    n_cmp++; if (flash_req_o !== 1'b0) begin n_bad++; $display("FAIL get_req_drop got %b want 0", flash_req_o); end
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL get_d_early got %b want 0", tl_d_valid_o); end
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'hDEAD_BEEF; flash_rerr_i = 1'b0;
    @(negedge clk); flash_rvalid_i = 1'b0;
    n_cmp++; if (tl_d_valid_o !== 1'b1) begin n_bad++; $display("FAIL get_d_valid got %b want 1", tl_d_valid_o); end
    n_cmp++; if (tl_d_opcode_o !== 3'd1) begin n_bad++; $display("FAIL get_d_opcode got %0d want 1", tl_d_opcode_o); end
    n_cmp++; if (tl_d_data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL get_d_data got %h want deadbeef", tl_d_data_o); end
    n_cmp++; if (tl_d_source_o !== 8'h12) begin n_bad++; $display("FAIL get_d_source got %h want 12", tl_d_source_o); end
    n_cmp++; if (tl_d_size_o !== 2'd2) begin n_bad++; $display("FAIL get_d_size got %0d want 2", tl_d_size_o); end
    n_cmp++; if (tl_d_error_o !== 1'b0) begin n_bad++; $display("FAIL get_d_error got %b want 0", tl_d_error_o); end
    @(negedge clk);
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL get_d_popped got %b want 0", tl_d_valid_o); end
  endtask

  task automatic test_put_error();
    drive_a(3'd0, 32'h2000_0000, 2'd2, 8'h03);
    @(negedge clk); idle_a();
    n_cmp++; if (flash_req_o !== 1'b0) begin n_bad++; $display("FAIL put_req got %b want 0", flash_req_o); end
    n_cmp++; if (tl_d_valid_o !== 1'b1) begin n_bad++; $display("FAIL put_d_valid got %b want 1", tl_d_valid_o); end
    n_cmp++; if (tl_d_opcode_o !== 3'd0) begin n_bad++; $display("FAIL put_d_opcode got %0d want 0", tl_d_opcode_o); end
    n_cmp++; if (tl_d_error_o !== 1'b1) begin n_bad++; $display("FAIL put_d_error got %b want 1", tl_d_error_o); end
    n_cmp++; if (tl_d_data_o !== 32'h0) begin n_bad++; $display("FAIL put_d_data got %h want 0", tl_d_data_o); end
    n_cmp++; if (tl_d_source_o !== 8'h03) begin n_bad++; $display("FAIL put_d_source got %h want 03", tl_d_source_o); end
    @(negedge clk);
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL put_d_popped got %b want 0", tl_d_valid_o); end
    n_cmp++; if (flash_req_o !== 1'b0) begin n_bad++; $display("FAIL put_req_after got %b want 0", flash_req_o); end
  endtask

  task automatic test_order();
    drive_a(3'd4, 32'h2000_0008, 2'd2, 8'h01);
    @(negedge clk); idle_a(); flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    drive_a(3'd4, 32'h3000_0000, 2'd2, 8'h02);
    n_cmp++; if (tl_a_ready_o !== 1'b1) begin n_bad++; $display("FAIL ord_a_ready got %b want 1", tl_a_ready_o); end
    @(negedge clk); idle_a();
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL ord_err_bypass got %b want 0", tl_d_valid_o); end
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'h1122_3344; flash_rerr_i = 1'b0;
    @(negedge clk); flash_rvalid_i = 1'b0;
    n_cmp++; if (tl_d_source_o !== 8'h01 || tl_d_valid_o !== 1'b1) begin n_bad++; $display("FAIL ord_first_src got %h/%b want 01/1", tl_d_source_o, tl_d_valid_o); end
    n_cmp++; if (tl_d_data_o !== 32'h1122_3344) begin n_bad++; $display("FAIL ord_first_data got %h want 11223344", tl_d_data_o); end
    @(negedge clk);
    n_cmp++; if (tl_d_source_o !== 8'h02 || tl_d_valid_o !== 1'b1) begin n_bad++; $display("FAIL ord_second_src got %h/%b want 02/1", tl_d_source_o, tl_d_valid_o); end
    n_cmp++; if (tl_d_error_o !== 1'b1) begin n_bad++; $display("FAIL ord_second_err got %b want 1", tl_d_error_o); end
    n_cmp++; if (tl_d_opcode_o !== 3'd1) begin n_bad++; $display("FAIL ord_second_opcode got %0d want 1", tl_d_opcode_o); end
    n_cmp++; if (tl_d_data_o !== 32'h0) begin n_bad++; $display("FAIL ord_second_data got %h want 0", tl_d_data_o); end
    @(negedge clk);
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL ord_drained got %b want 0", tl_d_valid_o); end
  endtask

  task automatic test_back_to_back();
    tl_d_ready_i = 1'b0;
    drive_a(3'd4, 32'h2000_0010, 2'd2, 8'h05);
    @(negedge clk); idle_a(); flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'hAAAA_0001; flash_rerr_i = 1'b0;
    drive_a(3'd4, 32'h2000_0014, 2'd2, 8'h06);
    n_cmp++; if (tl_a_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_second_ready got %b want 1", tl_a_ready_o); end
    @(negedge clk); idle_a(); flash_rvalid_i = 1'b0; flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'hAAAA_0002;
    drive_a(3'd4, 32'h2000_0018, 2'd2, 8'h07);
    n_cmp++; if (tl_a_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_full_stall got %b want 0", tl_a_ready_o); end
    @(negedge clk); flash_rvalid_i = 1'b0;
    n_cmp++; if (tl_a_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_full_stall2 got %b want 0", tl_a_ready_o); end
    n_cmp++; if (tl_d_valid_o !== 1'b1 || tl_d_source_o !== 8'h05) begin n_bad++; $display("FAIL b2b_hold_src got %b/%h want 1/05", tl_d_valid_o, tl_d_source_o); end
    n_cmp++; if (tl_d_data_o !== 32'hAAAA_0001) begin n_bad++; $display("FAIL b2b_hold_data got %h want aaaa0001", tl_d_data_o); end
    tl_d_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (tl_d_valid_o !== 1'b1 || tl_d_source_o !== 8'h06) begin n_bad++; $display("FAIL b2b_second_src got %b/%h want 1/06", tl_d_valid_o, tl_d_source_o); end
    n_cmp++; if (tl_d_data_o !== 32'hAAAA_0002) begin n_bad++; $display("FAIL b2b_second_data got %h want aaaa0002", tl_d_data_o); end
    n_cmp++; if (tl_a_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_unstall got %b want 1", tl_a_ready_o); end
    @(negedge clk); idle_a();
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_third_wait got %b want 0", tl_d_valid_o); end
    n_cmp++; if (flash_req_o !== 1'b1 || flash_addr_o !== 12'h006) begin n_bad++; $display("FAIL b2b_third_req got %b/%h want 1/006", flash_req_o, flash_addr_o); end
    flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'hAAAA_0003;
    @(negedge clk); flash_rvalid_i = 1'b0;
    n_cmp++; if (tl_d_valid_o !== 1'b1 || tl_d_source_o !== 8'h07) begin n_bad++; $display("FAIL b2b_third_src got %b/%h want 1/07", tl_d_valid_o, tl_d_source_o); end
    n_cmp++; if (tl_d_data_o !== 32'hAAAA_0003) begin n_bad++; $display("FAIL b2b_third_data got %h want aaaa0003", tl_d_data_o); end
    @(negedge clk);
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got %b want 0", tl_d_valid_o); end
  endtask

  task automatic test_top_addr();
    drive_a(3'd4, 32'h2000_3FFC, 2'd2, 8'h09);
    @(negedge clk); idle_a();
    n_cmp++; if (flash_addr_o !== 12'hFFF) begin n_bad++; $display("FAIL top_addr got %h want fff", flash_addr_o); end
    n_cmp++; if (flash_addr_o[11] !== 1'b1 || flash_addr_o[10:8] !== 3'd7 || flash_addr_o[7:0] !== 8'd255) begin n_bad++; $display("FAIL top_bank_page_word got %h want 1/7/255", flash_addr_o); end
    flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'h0000_0055; flash_rerr_i = 1'b1;
    @(negedge clk); flash_rvalid_i = 1'b0; flash_rerr_i = 1'b0;
    n_cmp++; if (tl_d_valid_o !== 1'b1 || tl_d_error_o !== 1'b1) begin n_bad++; $display("FAIL top_rerr got %b/%b want 1/1", tl_d_valid_o, tl_d_error_o); end
    n_cmp++; if (tl_d_opcode_o !== 3'd1 || tl_d_data_o !== 32'h55) begin n_bad++; $display("FAIL top_rerr_data got %0d/%h want 1/55", tl_d_opcode_o, tl_d_data_o); end
    @(negedge clk);
  endtask

  task automatic test_size_align();
    drive_a(3'd4, 32'h2000_0002, 2'd2, 8'h0B);
    @(negedge clk); idle_a();
    n_cmp++; if (flash_req_o !== 1'b0) begin n_bad++; $display("FAIL mis_req got %b want 0", flash_req_o); end
    n_cmp++; if (tl_d_valid_o !== 1'b1 || tl_d_error_o !== 1'b1) begin n_bad++; $display("FAIL mis_err got %b/%b want 1/1", tl_d_valid_o, tl_d_error_o); end
    @(negedge clk);
    drive_a(3'd4, 32'h2000_0007, 2'd0, 8'h04);
    @(negedge clk); idle_a();
    n_cmp++; if (flash_req_o !== 1'b1 || flash_addr_o !== 12'h001) begin n_bad++; $display("FAIL byte_req got %b/%h want 1/001", flash_req_o, flash_addr_o); end
    flash_ack_i = 1'b1;
    @(negedge clk); flash_ack_i = 1'b0;
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'hCAFE_F00D;
    @(negedge clk); flash_rvalid_i = 1'b0;
    n_cmp++; if (tl_d_data_o !== 32'hCAFE_F00D || tl_d_size_o !== 2'd0) begin n_bad++; $display("FAIL byte_data got %h/%0d want cafef00d/0", tl_d_data_o, tl_d_size_o); end
    n_cmp++; if (tl_d_error_o !== 1'b0 || tl_d_source_o !== 8'h04) begin n_bad++; $display("FAIL byte_src got %b/%h want 0/04", tl_d_error_o, tl_d_source_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive_a(3'd4, 32'h2000_0020, 2'd2, 8'h0A);
    @(negedge clk); idle_a();
    n_cmp++; if (flash_req_o !== 1'b1 || flash_addr_o !== 12'h008) begin n_bad++; $display("FAIL mid_req got %b/%h want 1/008", flash_req_o, flash_addr_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (flash_req_o !== 1'b0 || flash_addr_o !== 12'h000) begin n_bad++; $display("FAIL mid_rst_req got %b/%h want 0/000", flash_req_o, flash_addr_o); end
    n_cmp++; if (tl_a_ready_o !== 1'b1 || tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tl got %b/%b want 1/0", tl_a_ready_o, tl_d_valid_o); end
    @(negedge clk); rst = 1'b0;
    flash_rvalid_i = 1'b1; flash_rdata_i = 32'h0000_0077;
    @(negedge clk); flash_rvalid_i = 1'b0;
    n_cmp++; if (tl_d_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_stray got %b want 0", tl_d_valid_o); end
    @(negedge clk);
    n_cmp++; if (tl_d_valid_o !== 1'b0 || flash_req_o !== 1'b0) begin n_bad++; $display("FAIL mid_quiet got %b/%b want 0/0", tl_d_valid_o, flash_req_o); end
  endtask

  initial begin
    rst = 1'b1;
    tl_a_valid_i = 1'b0; tl_a_opcode_i = 3'd0; tl_a_address_i = 32'h0;
    tl_a_size_i = 2'd0; tl_a_source_i = 8'h0; tl_d_ready_i = 1'b1;
    flash_ack_i = 1'b0; flash_rvalid_i = 1'b0; flash_rdata_i = 32'h0; flash_rerr_i = 1'b0;
    test_reset();
    test_get_legal();
    test_put_error();
    test_order();
    test_back_to_back();
    test_top_addr();
    test_size_align();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
